// File: rtl/stopwatch_counter.sv
// Prescaled decimal stopwatch counter with debounced start/stop/clear buttons.
// Optional lap-hold button enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter #(
    parameter int TICK_DIV        = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_COUNT       = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic        btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        btn_lap,
`endif
    input  logic        dir,
    input  logic        load,
    input  logic [13:0] preset,
    output logic [31:0] number,
    output logic        running,
    output logic        wrapped
);

`ifdef STOPWATCH_LAP_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_CLEAR = 2;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]   MAX_C   = 14'(MAX_COUNT);

    typedef enum logic {
        STOPPED,
        RUNNING
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [NB-1:0]   raw;
    logic [NB-1:0]   sync1;
    logic [NB-1:0]   sync2;
    logic [NB-1:0]   level;
    logic [NB-1:0]   level_q;
    logic [NB-1:0]   press;
    logic [CW-1:0]   db_cnt [NB];
    logic [PW-1:0]   presc;
    logic [13:0]     count;
    logic [13:0]     clamped;
    logic            start_p;
    logic            stop_p;
    logic            clear_p;
    logic            tick;
    logic            lap_hold;

`ifdef STOPWATCH_LAP_EN
    assign raw = {btn_lap, btn_clear, btn_stop, btn_start};
`else
    assign raw = {btn_clear, btn_stop, btn_start};
`endif

    assign press   = level & ~level_q;
    assign start_p = press[B_START];
    assign stop_p  = press[B_STOP];
    assign clear_p = press[B_CLEAR];
    assign clamped = (preset > MAX_C) ? MAX_C : preset;

    // A stop or clear in the same cycle suppresses the tick.
    assign tick = (state == RUNNING) && (presc == PS_LAST)
                  && !clear_p && !stop_p;

    // Synchronise each button, then require a stable level before it changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STOPPED;
        end else begin
            state <= next_state;
        end
    end

    // Next state: clear beats stop, stop beats start.
    always_comb begin
        next_state = state;
        if (clear_p) begin
            next_state = STOPPED;
        end else if (stop_p) begin
            next_state = STOPPED;
        end else if (start_p) begin
            next_state = RUNNING;
        end
    end

    // Prescaler, count, wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            count   <= '0;
            wrapped <= 1'b0;
        end else if (clear_p) begin
            presc   <= '0;
            count   <= '0;
            wrapped <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            if (state == STOPPED && start_p && !stop_p) begin
                presc <= '0;
            end else if (state == RUNNING && !stop_p) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            if (state == STOPPED && load) begin
                count <= clamped;
            end else if (tick) begin
                if (!dir) begin
                    if (count >= MAX_C) begin
                        count   <= '0;
                        wrapped <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end else begin
                    if (count == '0) begin
                        count   <= MAX_C;
                        wrapped <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap toggles the display freeze while running; stop/clear release it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_hold <= 1'b0;
        end else if (clear_p || stop_p) begin
            lap_hold <= 1'b0;
        end else if (press[3] && state == RUNNING) begin
            lap_hold <= ~lap_hold;
        end
    end
`else
    assign lap_hold = 1'b0;
`endif

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            number  <= '0;
            running <= 1'b0;
        end else begin
            if (!lap_hold) begin
                number <= {18'b0, count};
            end
            running <= (state == RUNNING);
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with small tick/debounce constants.
// Lap-hold checks run only when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start;
    logic        btn_stop;
    logic        btn_clear;
    logic        btn_lap;
    logic        dir;
    logic        load;
    logic [13:0] preset;
    logic [31:0] number;
    logic        running;
    logic        wrapped;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    stopwatch_counter #(
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (3),
        .MAX_COUNT       (9999)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_clear (btn_clear),
`ifdef STOPWATCH_LAP_EN
        .btn_lap   (btn_lap),
`endif
        .dir       (dir),
        .load      (load),
        .preset    (preset),
        .number    (number),
        .running   (running),
        .wrapped   (wrapped)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_start = v;
            1: btn_stop  = v;
            default: btn_clear = v;
        endcase
    endtask

    // Raw press long enough to debounce; returns just after the acting edge.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        step(6);
        set_btn(b, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        dir       = 1'b0;
        load      = 1'b0;
        preset    = '0;
        step(2);
        chk("rst_number", number, 0);
        chk("rst_running", {31'b0, running}, 0);
        chk("rst_wrapped", {31'b0, wrapped}, 0);
        rst = 1'b0;

        // 1: held start, latency and tick rate
        btn_start = 1'b1;
        step(6);
        chk("t1_run_early", {31'b0, running}, 0);
        step(1);
        chk("t1_run_on", {31'b0, running}, 1);
        step(3);
        btn_start = 1'b0;
        chk("t1_num_c10", number, 0);
        step(1);
        chk("t1_num_c11", number, 1);
        step(3);
        chk("t1_num_c14", number, 1);
        step(1);
        chk("t1_num_c15", number, 2);
        chk("t1_wrap", {31'b0, wrapped}, 0);
        press(2);
        step(1);
        chk("t1_clr_num", number, 0);
        chk("t1_clr_run", {31'b0, running}, 0);
        step(8);

        // 2: bouncing start never debounces
        for (int i = 0; i < 8; i++) begin
            btn_start = (i % 2 == 1);
            step(1);
        end
        btn_start = 1'b0;
        step(10);
        chk("t2_run", {31'b0, running}, 0);
        chk("t2_num", number, 0);

        // 3: up-count wrap 9998 -> 9999 -> 0
        preset = 14'd9998;
        load   = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        chk("t3_load", number, 9998);
        press(0);
        step(4);
        chk("t3_nowrap", {31'b0, wrapped}, 0);
        chk("t3_num_hold", number, 9998);
        step(1);
        chk("t3_num_9999", number, 9999);
        step(3);
        chk("t3_wrap", {31'b0, wrapped}, 1);
        step(1);
        chk("t3_num_0", number, 0);
        chk("t3_wrap_end", {31'b0, wrapped}, 0);
        press(2);
        step(8);

        // 4: preset clamp, then count down
        preset = 14'h3FFF;
        load   = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        chk("t4_clamp", number, 9999);
        dir = 1'b1;
        press(0);
        step(4);
        chk("t4_nowrap", {31'b0, wrapped}, 0);
        step(1);
        chk("t4_9998", number, 9998);
        step(4);
        chk("t4_9997", number, 9997);
        press(2);
        step(8);
        dir = 1'b0;

        // 5: clear+stop coincide with a tick at count 42
        preset = 14'd41;
        load   = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        press(0);
        step(2);
        btn_clear = 1'b1;
        btn_stop  = 1'b1;
        step(6);
        btn_clear = 1'b0;
        btn_stop  = 1'b0;
        chk("t5_num_42", number, 42);
        chk("t5_wrap_a", {31'b0, wrapped}, 0);
        step(1);
        chk("t5_num_0", number, 0);
        chk("t5_run", {31'b0, running}, 0);
        chk("t5_wrap_b", {31'b0, wrapped}, 0);
        step(8);
        press(0);
        step(4);
        chk("t5_first_tick_wait", number, 0);
        step(1);
        chk("t5_first_tick", number, 1);

        // 6: reset mid-run at 123
        press(1);
        step(1);
        preset = 14'd122;
        load   = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        press(0);
        step(5);
        chk("t6_num_123", number, 123);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_num", number, 0);
        chk("t6_run", {31'b0, running}, 0);
        chk("t6_wrap", {31'b0, wrapped}, 0);

`ifdef STOPWATCH_LAP_EN
        preset = 14'd6;
        load   = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        press(0);
        btn_lap = 1'b1;
        step(4);
        btn_lap = 1'b0;
        step(1);
        chk("lap_num_7", number, 7);
        step(4);
        chk("lap_hold_a", number, 7);
        btn_lap = 1'b1;
        step(4);
        btn_lap = 1'b0;
        chk("lap_hold_b", number, 7);
        step(2);
        chk("lap_hold_c", number, 7);
        step(1);
        chk("lap_release", number, 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
